// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in over WIDTH clock cycles.
// A single full-subtractor cell consumes one operand bit per clock, LSB first.
// The result bits enter the result register from the MSB side. The final
// borrow and the signed-overflow flag are registered on the completion edge.
// After a completion, diff/borrw/ovf hold their values until the next one.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrw,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrw_q, borrw_d;
   logic             ovf_q, ovf_d;

   logic             a0_s, b0_s, d_s, br_next_s;
   logic [WIDTH-1:0] res_shift_s;

   // Subtractor cell and next-state logic; on the last bit a0/b0 are the operand sign bits
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      diff_d  = diff_q;
      borrw_d = borrw_q;
      ovf_d   = ovf_q;

      a0_s        = a_sh_q[0];
      b0_s        = b_sh_q[0];
      d_s         = a0_s ^ b0_s ^ br_q;
      br_next_s   = (~a0_s & b0_s) | (~(a0_s ^ b0_s) & br_q);
      res_shift_s = {d_s, res_q[WIDTH-1:1]};

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = borrow_in;
               res_d   = {WIDTH{1'b0}};
               cnt_d   = {CW{1'b0}};
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            res_d  = res_shift_s;
            br_d   = br_next_s;
            cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_BIT) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               diff_d  = res_shift_s;
               borrw_d = br_next_s;
               ovf_d   = (a0_s != b0_s) && (d_s != a0_s);
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_sh_q  <= {WIDTH{1'b0}};
         b_sh_q  <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         br_q    <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= {WIDTH{1'b0}};
         borrw_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         borrw_q <= borrw_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign diff  = diff_q;
   assign borrw = borrw_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=8 and a WIDTH=2 instance. Accepted starts
// push an arithmetic expectation (with its due cycle) into a queue. A monitor pops
// and compares on every done pulse and also checks busy run length and result
// stability between completions.
module tb_serial_subtractor;

   typedef struct {
      longint diff;
      logic   borrw;
      logic   ovf;
      int     cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0, bi8 = 1'b0, busy8, done8, borrw8, ovf8;
   logic [7:0] a8 = 8'd0, b8 = 8'd0, diff8;
   logic       start2 = 1'b0, bi2 = 1'b0, busy2, done2, borrw2, ovf2;
   logic [1:0] a2 = 2'd0, b2 = 2'd0, diff2;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t q8[$];
   exp_t q2[$];

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
      .busy(busy8), .done(done8), .diff(diff8), .borrw(borrw8), .ovf(ovf8));

   serial_subtractor #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .borrow_in(bi2),
      .busy(busy2), .done(done2), .diff(diff2), .borrw(borrw2), .ovf(ovf2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic exp_t model(input int w, input longint a, input longint b,
                                  input longint bi, input int due);
      exp_t   e;
      longint span = 64'sd1 <<< w;
      longint half = 64'sd1 <<< (w - 1);
      longint sa   = (a >= half) ? a - span : a;
      longint sb   = (b >= half) ? b - span : b;
      longint r    = sa - sb - bi;
      e.diff  = (a - b - bi) & (span - 64'sd1);
      e.borrw = (a < b + bi);
      e.ovf   = (r < -half) || (r > half - 64'sd1);
      e.cyc   = due;
      return e;
   endfunction

   // Acceptance observer: an edge with start=1 and busy=0 launches an operation
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         q8.delete();
         q2.delete();
      end else begin
         if (start8 && !busy8) q8.push_back(model(8, longint'(a8), longint'(b8), longint'(bi8), cyc + 8));
         if (start2 && !busy2) q2.push_back(model(2, longint'(a2), longint'(b2), longint'(bi2), cyc + 2));
      end
   end

   int   run8 = 0, run2 = 0;
   logic [7:0] last8 = 8'd0;
   logic [1:0] last2 = 2'd0;
   logic lb8 = 1'b0, lo8 = 1'b0, lb2 = 1'b0, lo2 = 1'b0;

   // Monitor: scoreboard pop on done, busy length and output hold checks
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         run8 = 0; run2 = 0;
         last8 = 8'd0; last2 = 2'd0;
         lb8 = 1'b0; lo8 = 1'b0; lb2 = 1'b0; lo2 = 1'b0;
         if (done8 || done2) chk("done_in_reset", 1, 0);
      end else begin
         if (busy8) run8++;
         else if (run8 != 0) begin chk("busy8_len", run8, 8); run8 = 0; end
         if (busy2) run2++;
         else if (run2 != 0) begin chk("busy2_len", run2, 2); run2 = 0; end
         if (done8) begin
            if (q8.size() == 0) chk("w8_unexpected_done", 1, 0);
            else begin
               e = q8.pop_front();
               chk("w8_diff", longint'(diff8), e.diff);
               chk("w8_borrw", longint'(borrw8), longint'(e.borrw));
               chk("w8_ovf", longint'(ovf8), longint'(e.ovf));
               chk("w8_latency", cyc, e.cyc);
            end
            last8 = diff8; lb8 = borrw8; lo8 = ovf8;
         end else begin
            chk("w8_hold", {diff8, borrw8, ovf8}, {last8, lb8, lo8});
         end
         if (done2) begin
            if (q2.size() == 0) chk("w2_unexpected_done", 1, 0);
            else begin
               e = q2.pop_front();
               chk("w2_diff", longint'(diff2), e.diff);
               chk("w2_borrw", longint'(borrw2), longint'(e.borrw));
               chk("w2_ovf", longint'(ovf2), longint'(e.ovf));
               chk("w2_latency", cyc, e.cyc);
            end
            last2 = diff2; lb2 = borrw2; lo2 = ovf2;
         end else begin
            chk("w2_hold", {diff2, borrw2, ovf2}, {last2, lb2, lo2});
         end
      end
   end

   task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibi);
      int n = 0;
      while (busy8 && n < 40) begin @(negedge clk); n++; end
      a8 = ia; b8 = ib; bi8 = ibi; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      n = 0;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
         a8 = 8'($urandom); b8 = 8'($urandom);
         start8 = (n == 3) ? 1'b1 : 1'b0;
      end
      start8 = 1'b0;
      if (!done8) chk("w8_timeout", 0, 1);
   endtask

   task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ibi);
      int n = 0;
      while (busy2 && n < 20) begin @(negedge clk); n++; end
      a2 = ia; b2 = ib; bi2 = ibi; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      a2 = 2'($urandom); b2 = 2'($urandom);
      n = 0;
      while (!done2 && n < 20) begin @(negedge clk); n++; end
      if (!done2) chk("w2_timeout", 0, 1);
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1);
   end

   initial begin
      #2;
      chk("reset_outputs8", {busy8, done8, diff8, borrw8, ovf8}, 0);
      chk("reset_outputs2", {busy2, done2, diff2, borrw2, ovf2}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed WIDTH=8 cases
      op8(8'h05, 8'h03, 1'b0);
      op8(8'h03, 8'h05, 1'b0);
      op8(8'h80, 8'h01, 1'b0);
      op8(8'h7F, 8'hFF, 1'b0);
      op8(8'h00, 8'h00, 1'b1);
      // Known answers, independent of the model
      chk("kat_00_00_1_diff", longint'(diff8), 64'hFF);
      chk("kat_00_00_1_borrw", longint'(borrw8), 64'd1);

      // start held high: a new operation is accepted in every done cycle
      start8 = 1'b1;
      for (int i = 0; i < 45; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
         @(negedge clk);
      end
      start8 = 1'b0;
      repeat (10) @(negedge clk);

      // Random operations
      for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

      // Reset during the fourth cycle of an operation
      a8 = 8'h5A; b8 = 8'h13; bi8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midop_reset_busy", longint'(busy8), 0);
      chk("midop_reset_done", longint'(done8), 0);
      chk("midop_reset_diff", longint'(diff8), 0);
      chk("midop_reset_borrw", longint'(borrw8), 0);
      chk("midop_reset_ovf", longint'(ovf8), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_done_after_reset", q8.size(), 0);
      op8(8'h10, 8'h20, 1'b1);

      // WIDTH=2 exhaustive, including the half-subtractor corner cases
      for (int bi = 0; bi < 2; bi++)
         for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
               op2(2'(x), 2'(y), 1'(bi));
      op2(2'd0, 2'd1, 1'b0);
      chk("hs_0m1_diff_lsb", longint'(diff2[0]), 1);
      chk("hs_0m1_borrow", longint'(borrw2), 1);
      op2(2'd1, 2'd1, 1'b0);
      chk("hs_1m1", {diff2[0], borrw2}, 0);
      op2(2'd1, 2'd0, 1'b0);
      chk("hs_1m0", {diff2[0], borrw2}, 2);
      op2(2'd0, 2'd0, 1'b0);
      chk("hs_0m0", {diff2[0], borrw2}, 0);

      repeat (12) @(negedge clk);
      chk("q8_drained", q8.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
